tpu_ctrl_decode: RTL and testbench
==================================

# tpu_ctrl_decode

Control sequencer and instruction decoder for the 16-bit TPU core, directly upstream of `reg_file`. It fetches a 16-bit instruction, decodes the register selects, the ALU op and the immediate, and walks a fixed multi-cycle FSM. The FSM issues the register-file enable and write-enable strobes, so `reg_file` sees exactly one read cycle and at most one write cycle per instruction.

## Interface
Parameters:
- none (data width 16 and register count 8 are fixed by `reg_file`)

Ports:
- I_clk, in, 1: clock; all state updates on the rising edge.
- I_reset, in, 1: synchronous, active-high reset.
- I_en, in, 1: core enable; low freezes the FSM and forces all strobes low.
- I_stall, in, 1: instruction memory not ready; extends the FETCH state.
- I_instr, in, 16: instruction word; sampled on the edge that leaves FETCH.
- O_fetch, out, 1: high while in FETCH and I_en=1.
- O_regen, out, 1: `reg_file` I_en; high in READ and WB when I_en=1.
- O_we, out, 1: `reg_file` I_we; high in WB only, for writing opcodes, when I_en=1.
- O_aluen, out, 1: high in EXEC when I_en=1.
- O_selA / O_selB / O_selD, out, 3 each: register selects to `reg_file`.
- O_aluop, out, 5: {opcode, flag}.
- O_imm, out, 16: decoded immediate.
- O_state, out, 3: current state encoding.
- O_halted, out, 1: high in HALT.

## Operation
- Instruction fields: opcode=[15:12], rD=[11:9], flag=[8], rA=[7:5], rB=[4:2], imm8=[7:0].
- FSM states and encodings: FETCH=0, DECODE=1, READ=2, EXEC=3, WB=4, HALT=5.
- FSM transitions:
  - FETCH→DECODE when I_stall=0. I_instr is latched into an internal register on this edge.
  - DECODE→READ, except opcode 0xF goes DECODE→HALT.
  - READ→EXEC→WB→FETCH.
  - HALT holds until I_reset.
- Decode is registered on the DECODE→READ edge:
  - O_selA=rA, O_selB=rB, O_selD=rD, O_aluop={opcode,flag}.
  - O_imm = flag ? {imm8, 8'h00} : {8'h00, imm8}.
- Decoded outputs hold their value until the next DECODE→READ edge.
- Writing opcodes are 0x0–0x8 and 0xA. Non-writing opcodes are 0x9, 0xB, 0xC, 0xD, 0xE (NOP) and 0xF (HALT). For a non-writing opcode, O_we stays 0 in WB.
- I_en=0:
  - The state register and all field registers hold.
  - O_fetch, O_regen, O_we and O_aluen are all 0.
  - Operation resumes in the same state once I_en returns to 1.
- I_stall is ignored in every state except FETCH.

## Timing
- Reset: state=FETCH; internal instr=0x0000; O_selA/B/D=0; O_aluop=0; O_imm=0; O_halted=0.
- Strobe values during and after reset:
  - The strobes are combinational from state and I_en.
  - In the cycle after reset, O_fetch=1 if I_en=1; O_regen=O_we=O_aluen=0.
- Latency: 5 cycles per instruction with no stall (FETCH, DECODE, READ, EXEC, WB). Each stall cycle adds one cycle.
- Selects are valid from the first cycle of READ, so `reg_file` read data appears in EXEC.
- O_selD and O_we are valid together for the whole WB cycle; the write lands on the WB→FETCH edge.
- I_reset during any state, including HALT or mid-stall, returns the FSM to FETCH on that edge. Reset has priority over I_en and I_stall.
- I_en=0 and I_stall=1 together in FETCH: hold, O_fetch=0.
- The DECODE state gives no early exit; every instruction, including NOP, takes all 5 states except HALT.

## Test plan
- Reset then I_en=1, I_instr=0x0404 (ADD r2,r0,r1) → O_state goes 0,1,2,3,4,0. In READ: O_selA=0, O_selB=1, O_selD=2, O_aluop=5'b00000. O_regen=1 in READ and WB; O_we=1 in WB only; O_aluen=1 in EXEC only.
- I_instr=0x8844, then 0x8944 (LOAD r4) → O_imm=0x0044, then 0x4400. O_selD=4 and O_we=1 in WB for both.
- I_instr=0xB000 (STORE) and 0xE000 (NOP) → full 5-state walk with O_we=0 throughout.
- I_stall=1 for 3 cycles in FETCH, instr=0x0404 → O_fetch held high 4 cycles. I_instr is latched only on the stall-release edge; later changes to I_instr have no effect.
- I_en dropped to 0 for 2 cycles in EXEC → O_state stays 3 and all strobes are 0. On re-enable, one EXEC cycle, then WB with O_we=1.
- I_instr=0xF000 → DECODE→HALT, O_halted=1, O_we never asserts. Asserting I_reset for 1 cycle → O_state=0, O_halted=0, and all field outputs read 0.

Source files
------------

// File: rtl/tpu_ctrl_decode.sv
// rtl/tpu_ctrl_decode.sv - TPU control sequencer and instruction decoder
// Ports:
//   I_clk, I_reset (sync, active-high), I_en (core enable), I_stall (imem not ready)
//   I_instr[15:0]                 instruction word, captured when leaving FETCH
//   O_fetch, O_regen, O_we, O_aluen  combinational strobes from state and I_en
//   O_selA/O_selB/O_selD[2:0]     register selects to reg_file
//   O_aluop[4:0]                  {opcode, flag}
//   O_imm[15:0]                   decoded immediate
//   O_state[2:0], O_halted        FSM state and halt indication
module tpu_ctrl_decode (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic        I_stall,
    input  logic [15:0] I_instr,
    output logic        O_fetch,
    output logic        O_regen,
    output logic        O_we,
    output logic        O_aluen,
    output logic [2:0]  O_selA,
    output logic [2:0]  O_selB,
    output logic [2:0]  O_selD,
    output logic [4:0]  O_aluop,
    output logic [15:0] O_imm,
    output logic [2:0]  O_state,
    output logic        O_halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] instr_q;
    logic [3:0]  opcode;
    logic        writes;

    assign opcode = instr_q[15:12];

    // Opcodes 0x0-0x8 and 0xA write back; everything else leaves reg_file untouched.
    always_comb begin
        writes = 1'b0;
        if (opcode <= 4'h8 || opcode == 4'hA) begin
            writes = 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state   <= S_FETCH;
            instr_q <= 16'h0000;
            O_selA  <= 3'd0;
            O_selB  <= 3'd0;
            O_selD  <= 3'd0;
            O_aluop <= 5'd0;
            O_imm   <= 16'h0000;
        end else if (I_en) begin
            state <= state_next;
            if (state == S_FETCH && !I_stall) begin
                instr_q <= I_instr;
            end
            // Fields are only refreshed when the instruction actually proceeds to READ,
            // so a HALT leaves the previous instruction's decode visible.
            if (state == S_DECODE && opcode != 4'hF) begin
                O_selA  <= instr_q[7:5];
                O_selB  <= instr_q[4:2];
                O_selD  <= instr_q[11:9];
                O_aluop <= {opcode, instr_q[8]};
                O_imm   <= instr_q[8] ? {instr_q[7:0], 8'h00} : {8'h00, instr_q[7:0]};
            end
        end
    end

    always_comb begin
        state_next = state;
        O_fetch    = 1'b0;
        O_regen    = 1'b0;
        O_we       = 1'b0;
        O_aluen    = 1'b0;
        case (state)
            S_FETCH: begin
                O_fetch = I_en;
                if (!I_stall) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = (opcode == 4'hF) ? S_HALT : S_READ;
            end
            S_READ: begin
                O_regen    = I_en;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                O_aluen    = I_en;
                state_next = S_WB;
            end
            S_WB: begin
                O_regen    = I_en;
                O_we       = I_en & writes;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign O_state  = state;
    assign O_halted = (state == S_HALT);

endmodule

// File: tb/tb_tpu_ctrl_decode.sv
// tb/tb_tpu_ctrl_decode.sv - self-checking bench for tpu_ctrl_decode
module tb_tpu_ctrl_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        fetch, regen, we, aluen, halted;
    logic [2:0]  sel_a, sel_b, sel_d, state;
    logic [4:0]  aluop;
    logic [15:0] imm;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tpu_ctrl_decode dut (
        .I_clk    (clk),
        .I_reset  (reset),
        .I_en     (en),
        .I_stall  (stall),
        .I_instr  (instr),
        .O_fetch  (fetch),
        .O_regen  (regen),
        .O_we     (we),
        .O_aluen  (aluen),
        .O_selA   (sel_a),
        .O_selB   (sel_b),
        .O_selD   (sel_d),
        .O_aluop  (aluop),
        .O_imm    (imm),
        .O_state  (state),
        .O_halted (halted)
    );

    typedef struct {
        logic [15:0] instr;
        int          nstall;
        int          sa;
        int          sb;
        int          sd;
        int          op;
        int          im;
        bit          wr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic strobes(input string tag, input int st, input bit f, input bit r, input bit w, input bit a);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".fetch"}, int'(fetch), int'(f));
        chk({tag, ".regen"}, int'(regen), int'(r));
        chk({tag, ".we"}, int'(we), int'(w));
        chk({tag, ".aluen"}, int'(aluen), int'(a));
        chk({tag, ".halted"}, int'(halted), (st == 5) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode derived from the field layout with plain arithmetic.
    function automatic vec_t model(input logic [15:0] w, input int nstall);
        vec_t v;
        int   x, op, fl, i8;
        x      = int'(w);
        op     = x / 4096;
        fl     = (x / 256) % 2;
        i8     = x % 256;
        v.instr  = w;
        v.nstall = nstall;
        v.sa     = (x / 32) % 8;
        v.sb     = (x / 4) % 8;
        v.sd     = (x / 512) % 8;
        v.op     = op * 2 + fl;
        v.im     = fl ? i8 * 256 : i8;
        v.wr     = (op <= 8) || (op == 10);
        return v;
    endfunction

    // Entered 1 time unit after the edge that starts a FETCH cycle.
    task automatic do_instr(input vec_t v);
        for (int k = 0; k <= v.nstall; k++) begin
            stall = (k < v.nstall);
            instr = (k == v.nstall) ? v.instr : 16'($urandom);
            #1;
            strobes("fetch", 0, 1, 0, 0, 0);
            step();
        end
        stall = 1'($urandom);
        instr = 16'($urandom);
        #1;
        strobes("decode", 1, 0, 0, 0, 0);
        step();
        if (v.instr[15:12] == 4'hF) begin
            #1;
            strobes("halt", 5, 0, 0, 0, 0);
            return;
        end
        stall = 1'($urandom);
        #1;
        strobes("read", 2, 0, 1, 0, 0);
        chk("read.selA", int'(sel_a), v.sa);
        chk("read.selB", int'(sel_b), v.sb);
        chk("read.selD", int'(sel_d), v.sd);
        chk("read.aluop", int'(aluop), v.op);
        chk("read.imm", int'(imm), v.im);
        step();
        stall = 1'($urandom);
        #1;
        strobes("exec", 3, 0, 0, 0, 1);
        step();
        stall = 1'($urandom);
        #1;
        strobes("wb", 4, 0, 1, v.wr, 0);
        chk("wb.selD", int'(sel_d), v.sd);
        step();
    endtask

    initial begin
        vecs[0] = '{16'h0404, 0, 0, 1, 2, 0,  16'h0004, 1'b1};
        vecs[1] = '{16'h8844, 0, 2, 1, 4, 16, 16'h0044, 1'b1};
        vecs[2] = '{16'h8944, 0, 2, 1, 4, 17, 16'h4400, 1'b1};
        vecs[3] = '{16'hB000, 0, 0, 0, 0, 22, 16'h0000, 1'b0};
        vecs[4] = '{16'hE000, 0, 0, 0, 0, 28, 16'h0000, 1'b0};
        vecs[5] = '{16'h0404, 3, 0, 1, 2, 0,  16'h0004, 1'b1};

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        strobes("reset", 0, 1, 0, 0, 0);
        chk("reset.selA", int'(sel_a), 0);
        chk("reset.selB", int'(sel_b), 0);
        chk("reset.selD", int'(sel_d), 0);
        chk("reset.aluop", int'(aluop), 0);
        chk("reset.imm", int'(imm), 0);
        step();
        // Stall was low and instr 0: a write-capable 0x0000 is now in flight; drain it.
        #1;
        chk("reset_walk.state", int'(state), 1);
        step(); step(); step(); step();

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            do_instr(vecs[i]);
        end

        // en=0 with stall=1 in FETCH holds with no fetch strobe
        en = 1'b0;
        stall = 1'b1;
        #1;
        strobes("en0_stall", 0, 0, 0, 0, 0);
        step();
        #1;
        strobes("en0_stall2", 0, 0, 0, 0, 0);
        en = 1'b1;

        // Drop en for two cycles in EXEC
        stall = 1'b0;
        instr = 16'h0404;
        step();
        instr = 16'hFFFF;
        step();
        step();
        #1;
        strobes("pre_gap_exec", 3, 0, 0, 0, 1);
        en = 1'b0;
        #1;
        strobes("gap1", 3, 0, 0, 0, 0);
        step();
        #1;
        strobes("gap2", 3, 0, 0, 0, 0);
        step();
        en = 1'b1;
        #1;
        strobes("resume_exec", 3, 0, 0, 0, 1);
        step();
        #1;
        strobes("resume_wb", 4, 0, 1, 1, 0);
        step();

        // Randomized instructions against the reference model
        for (int i = 0; i < 25; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
            do_instr(model(w, $urandom_range(0, 2)));
        end

        // Reset mid-EXEC returns to FETCH
        do_instr(model(16'h3A5C, 0));
        stall = 1'b0;
        instr = 16'h1234;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        strobes("reset_exec", 0, 1, 0, 0, 0);
        chk("reset_exec.selD", int'(sel_d), 0);
        step();
        step(); step(); step(); step();

        // HALT then reset
        do_instr(model(16'h8944, 0));
        do_instr(model(16'hF000, 0));
        for (int k = 0; k < 3; k++) begin
            step();
            stall = 1'($urandom);
            #1;
            strobes("halt_hold", 5, 0, 0, 0, 0);
        end
        chk("halt.selD_held", int'(sel_d), 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        strobes("halt_reset", 0, 1, 0, 0, 0);
        chk("halt_reset.selA", int'(sel_a), 0);
        chk("halt_reset.selB", int'(sel_b), 0);
        chk("halt_reset.selD", int'(sel_d), 0);
        chk("halt_reset.aluop", int'(aluop), 0);
        chk("halt_reset.imm", int'(imm), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
